// File: rtl/mw_pipe_pkg.sv
// Package: mw_pipe_pkg
// Types, constants and helpers shared by the MEM->WB pipeline (mw_writeback_pipe
// and its slot register mw_slot_reg).
//   MW_MAX_STAGES : largest supported number of MEM->WB register slots
//   MW_XLEN       : datapath width carried by a slot
//   MW_REG_AW     : register-address width carried by a slot
//   mw_slot_t     : contents of one pipeline slot
//   MW_SLOT_RESET : value of a slot after reset (everything cleared)
//   mw_wb_value() : write-back value selected by a slot's mem_reg bit
package mw_pipe_pkg;

    localparam int MW_MAX_STAGES = 4;
    localparam int MW_XLEN       = 32;
    localparam int MW_REG_AW     = 5;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_reg;
        logic [MW_REG_AW-1:0] write_reg_addr;
        logic [MW_XLEN-1:0]   alu_result;
        logic [MW_XLEN-1:0]   mem_read_data;
    } mw_slot_t;

    localparam mw_slot_t MW_SLOT_RESET = '0;

    // Load data for loads, ALU result for everything else.
    function automatic logic [MW_XLEN-1:0] mw_wb_value(input mw_slot_t s);
        return s.mem_reg ? s.mem_read_data : s.alu_result;
    endfunction

endpackage

// File: rtl/mw_slot_reg.sv
// Module: mw_slot_reg
// One MEM->WB pipeline slot. Priority on each rising edge:
// rst (clear all) > flush (clear valid/reg_write, hold data) > stall (hold) > load.
// On load, reg_write is only kept for a valid instruction whose destination is
// not register 0 (when ZERO_SUPP is nonzero), so a captured slot never claims a
// pointless write.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   flush  in   kill this slot's instruction
//   stall  in   hold this slot
//   d      in   slot value to capture
//   q      out  registered slot value
module mw_slot_reg
    import mw_pipe_pkg::*;
#(
    parameter int ZERO_SUPP = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     stall,
    input  mw_slot_t d,
    output mw_slot_t q
);

    mw_slot_t d_cap;
    logic     addr_is_zero;

    assign addr_is_zero = (d.write_reg_addr == '0);

    always_comb begin
        d_cap           = d;
        d_cap.reg_write = d.valid & d.reg_write & ~((ZERO_SUPP != 0) & addr_is_zero);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= MW_SLOT_RESET;
        end else if (flush) begin
            q.valid     <= 1'b0;
            q.reg_write <= 1'b0;
        end else if (!stall) begin
            q <= d_cap;
        end
    end

endmodule

// File: rtl/mw_writeback_pipe.sv
// Module: mw_writeback_pipe
// MEM->WB pipeline stage: STAGES register slots carrying load data, ALU result,
// destination register and control, followed by the write-back mux. Also tells
// the hazard unit how many writes are in flight and whether a given source
// register has a pending write.
// Optional feature macro: MW_WRITEBACK_FWD_EN
//   defined   : fwd_data is the write-back value of the youngest valid slot
//               writing query_addr, fwd_valid = query_hit
//   undefined : fwd_valid = 0, fwd_data = 0, no compare-mux logic
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid                   MEM stage holds a real instruction
//   stall, flush               hold / kill every slot (flush wins)
//   mem_read_data, alu_result  MEM-stage data
//   write_reg_addr, reg_write  destination and its write enable
//   mem_reg                    1: write back load data, 0: ALU result
//   query_addr                 source register asked about by the hazard unit
//   out_valid, *_buffered      last slot contents
//   wb_data, wb_en             register-file write port
//   pending_writes             number of valid slots with reg_write=1
//   query_hit                  some valid writing slot targets query_addr (!=0)
//   fwd_valid, fwd_data        forwarding result (see macro above)
module mw_writeback_pipe
    import mw_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int STAGES    = 1,
    parameter int ZERO_SUPP = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [XLEN-1:0]              mem_read_data,
    input  logic [XLEN-1:0]              alu_result,
    input  logic [REG_AW-1:0]            write_reg_addr,
    input  logic                         reg_write,
    input  logic                         mem_reg,
    input  logic [REG_AW-1:0]            query_addr,
    output logic                         out_valid,
    output logic [XLEN-1:0]              mem_read_data_buffered,
    output logic [XLEN-1:0]              alu_result_buffered,
    output logic [REG_AW-1:0]            write_reg_addr_buffered,
    output logic                         reg_write_buffered,
    output logic                         mem_reg_buffered,
    output logic [XLEN-1:0]              wb_data,
    output logic                         wb_en,
    output logic [$clog2(STAGES+1)-1:0]  pending_writes,
    output logic                         query_hit,
    output logic                         fwd_valid,
    output logic [XLEN-1:0]              fwd_data
);

    localparam int PW_W = $clog2(STAGES + 1);

    // The slot type is fixed-width, so the port widths must match it.
    if (XLEN != MW_XLEN || REG_AW != MW_REG_AW) begin : g_bad_width
        $error("mw_writeback_pipe: XLEN/REG_AW must match mw_pipe_pkg widths");
    end
    if (STAGES < 1 || STAGES > MW_MAX_STAGES) begin : g_bad_stages
        $error("mw_writeback_pipe: STAGES must be in 1..MW_MAX_STAGES");
    end

    mw_slot_t            slot_in;
    mw_slot_t            slot_d [STAGES];
    mw_slot_t            slot_q [STAGES];
    mw_slot_t            last_slot;
    logic [STAGES-1:0]   slot_match;

    always_comb begin
        slot_in                = MW_SLOT_RESET;
        slot_in.valid          = in_valid;
        slot_in.reg_write      = reg_write;
        slot_in.mem_reg        = mem_reg;
        slot_in.write_reg_addr = write_reg_addr;
        slot_in.alu_result     = alu_result;
        slot_in.mem_read_data  = mem_read_data;
    end

    // Slot 0 is youngest; slot STAGES-1 feeds write-back.
    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign slot_d[g] = slot_in;
        end else begin : g_tail
            assign slot_d[g] = slot_q[g-1];
        end

        mw_slot_reg #(
            .ZERO_SUPP (ZERO_SUPP)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .stall (stall),
            .d     (slot_d[g]),
            .q     (slot_q[g])
        );
    end

    assign last_slot               = slot_q[STAGES-1];
    assign out_valid               = last_slot.valid;
    assign mem_read_data_buffered  = last_slot.mem_read_data;
    assign alu_result_buffered     = last_slot.alu_result;
    assign write_reg_addr_buffered = last_slot.write_reg_addr;
    assign reg_write_buffered      = last_slot.reg_write;
    assign mem_reg_buffered        = last_slot.mem_reg;
    assign wb_data                 = mw_wb_value(last_slot);
    assign wb_en                   = last_slot.valid & last_slot.reg_write;

    // Count can never exceed STAGES, which fits PW_W bits by construction.
    always_comb begin
        pending_writes = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (slot_q[i].valid && slot_q[i].reg_write) begin
                pending_writes = pending_writes + PW_W'(1);
            end
        end
    end

    // Register 0 is never a real dependency, so it never matches.
    always_comb begin
        slot_match = '0;
        for (int i = 0; i < STAGES; i++) begin
            slot_match[i] = slot_q[i].valid && slot_q[i].reg_write &&
                            (slot_q[i].write_reg_addr == query_addr) &&
                            (query_addr != '0);
        end
    end

    assign query_hit = |slot_match;

`ifdef MW_WRITEBACK_FWD_EN
    logic [XLEN-1:0] fwd_sel;

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd_sel = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (slot_match[i]) begin
                fwd_sel = mw_wb_value(slot_q[i]);
            end
        end
    end

    assign fwd_valid = query_hit;
    assign fwd_data  = fwd_sel;
`else
    assign fwd_valid = 1'b0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mw_writeback_pipe.sv
// Testbench: tb_mw_writeback_pipe
// Runs three mw_writeback_pipe instances (STAGES = 1, 2, 3) on shared inputs and
// compares every output against an age-ordered list model after each clock edge,
// plus directed scenarios with literal expectations.
module tb_mw_writeback_pipe;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, reg_write, mem_reg;
    logic [31:0] mem_read_data, alu_result;
    logic [4:0]  write_reg_addr, query_addr;

    logic        ov   [ND];
    logic [31:0] mrd_b[ND];
    logic [31:0] alu_b[ND];
    logic [4:0]  wra_b[ND];
    logic        rw_b [ND];
    logic        mr_b [ND];
    logic [31:0] wbd  [ND];
    logic        wbe  [ND];
    logic [2:0]  pend [ND];
    logic        qh   [ND];
    logic        fv   [ND];
    logic [31:0] fwdd [ND];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int S = g + 1;
        logic [$clog2(S+1)-1:0] pw;

        mw_writeback_pipe #(
            .XLEN      (32),
            .REG_AW    (5),
            .STAGES    (S),
            .ZERO_SUPP (1)
        ) u_dut (
            .clk                     (clk),
            .rst                     (rst),
            .in_valid                (in_valid),
            .stall                   (stall),
            .flush                   (flush),
            .mem_read_data           (mem_read_data),
            .alu_result              (alu_result),
            .write_reg_addr          (write_reg_addr),
            .reg_write               (reg_write),
            .mem_reg                 (mem_reg),
            .query_addr              (query_addr),
            .out_valid               (ov[g]),
            .mem_read_data_buffered  (mrd_b[g]),
            .alu_result_buffered     (alu_b[g]),
            .write_reg_addr_buffered (wra_b[g]),
            .reg_write_buffered      (rw_b[g]),
            .mem_reg_buffered        (mr_b[g]),
            .wb_data                 (wbd[g]),
            .wb_en                   (wbe[g]),
            .pending_writes          (pw),
            .query_hit               (qh[g]),
            .fwd_valid               (fv[g]),
            .fwd_data                (fwdd[g])
        );

        assign pend[g] = 3'(pw);
    end

    // Reference model: per instance, the instructions in flight ordered by age
    // (index 0 = most recently accepted, index S-1 = the one being written back).
    typedef struct {
        bit        v;
        bit        rw;
        bit        mr;
        bit [4:0]  a;
        bit [31:0] alu;
        bit [31:0] mrd;
    } ent_t;

    ent_t pipe [ND][4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        ent_t e;
        e.v   = in_valid;
        e.rw  = in_valid && reg_write && (write_reg_addr != 5'd0);
        e.mr  = mem_reg;
        e.a   = write_reg_addr;
        e.alu = alu_result;
        e.mrd = mem_read_data;
        for (int g = 0; g < ND; g++) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) pipe[g][i] = '{default: 0};
            end else if (flush) begin
                for (int i = 0; i < g + 1; i++) begin
                    pipe[g][i].v  = 1'b0;
                    pipe[g][i].rw = 1'b0;
                end
            end else if (!stall) begin
                for (int i = g; i > 0; i--) pipe[g][i] = pipe[g][i-1];
                pipe[g][0] = e;
            end
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < ND; g++) begin
            ent_t        last;
            int          cnt;
            bit          hit;
            bit [31:0]   fwd;
            string       p;
            last = pipe[g][g];
            cnt  = 0;
            hit  = 1'b0;
            fwd  = '0;
            p    = $sformatf("s%0d_", g + 1);
            for (int i = 0; i <= g; i++) begin
                if (pipe[g][i].v && pipe[g][i].rw) begin
                    cnt++;
                    if (pipe[g][i].a == query_addr && query_addr != 5'd0 && !hit) begin
                        hit = 1'b1;
                        fwd = pipe[g][i].mr ? pipe[g][i].mrd : pipe[g][i].alu;
                    end
                end
            end
            chk({p, "out_valid"}, 32'(ov[g]), 32'(last.v));
            chk({p, "mrd_buf"},   mrd_b[g],   last.mrd);
            chk({p, "alu_buf"},   alu_b[g],   last.alu);
            chk({p, "addr_buf"},  32'(wra_b[g]), 32'(last.a));
            chk({p, "rw_buf"},    32'(rw_b[g]),  32'(last.rw));
            chk({p, "mr_buf"},    32'(mr_b[g]),  32'(last.mr));
            chk({p, "wb_data"},   wbd[g], last.mr ? last.mrd : last.alu);
            chk({p, "wb_en"},     32'(wbe[g]),  32'(last.v && last.rw));
            chk({p, "pending"},   32'(pend[g]), 32'(cnt));
            chk({p, "query_hit"}, 32'(qh[g]),   32'(hit));
`ifdef MW_WRITEBACK_FWD_EN
            chk({p, "fwd_valid"}, 32'(fv[g]), 32'(hit));
            chk({p, "fwd_data"},  fwdd[g],    fwd);
`else
            chk({p, "fwd_valid"}, 32'(fv[g]), 32'd0);
            chk({p, "fwd_data"},  fwdd[g],    32'd0);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] a,
                         input logic [31:0] alu, input logic mr, input logic [31:0] mrd);
        in_valid       = v;
        reg_write      = rw;
        write_reg_addr = a;
        alu_result     = alu;
        mem_reg        = mr;
        mem_read_data  = mrd;
    endtask

    initial begin
        for (int g = 0; g < ND; g++)
            for (int i = 0; i < 4; i++) pipe[g][i] = '{default: 0};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; query_addr = 5'd0;
        drive(1'b1, 1'b1, 5'd3, 32'h55, 1'b0, 32'h66);
        step();
        step();
        for (int g = 0; g < ND; g++) begin
            chk("reset_wb_en",   32'(wbe[g]),  32'd0);
            chk("reset_pending", 32'(pend[g]), 32'd0);
        end
        rst = 1'b0;

        // ALU write to r5 through two slots.
        drive(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 32'h9999);
        step();
        chk("t1_pending_c1", 32'(pend[1]), 32'd1);
        chk("t1_wb_en_c1",   32'(wbe[1]),  32'd0);
        chk("t1_s1_wb_en",   32'(wbe[0]),  32'd1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        step();
        chk("t1_wb_en_c2",   32'(wbe[1]),  32'd1);
        chk("t1_wb_data_c2", wbd[1],       32'h1234);
        chk("t1_addr_c2",    32'(wra_b[1]), 32'd5);
        chk("t1_pending_c2", 32'(pend[1]), 32'd1);

        // Load write-back selects memory data.
        drive(1'b1, 1'b1, 5'd9, 32'h10, 1'b1, 32'hDEADBEEF);
        step();
        chk("t2_wb_data", wbd[0], 32'hDEADBEEF);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        step(); step(); step();

        // Fill three writes, stall four cycles, then flush+stall.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 32'h0);
            step();
        end
        chk("t3_pending_full", 32'(pend[2]), 32'd3);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd20, $urandom, 1'b0, $urandom);
            step();
            chk("t3_stall_pending", 32'(pend[2]), 32'd3);
            chk("t3_stall_addr",    32'(wra_b[2]), 32'd1);
            chk("t3_stall_wb_data", wbd[2], 32'h101);
        end
        flush = 1'b1;
        step();
        chk("t3_flush_pending", 32'(pend[2]), 32'd0);
        chk("t3_flush_wb_en",   32'(wbe[2]),  32'd0);
        flush = 1'b0; stall = 1'b0;

        // Write to r0 is suppressed.
        drive(1'b1, 1'b1, 5'd0, 32'h77, 1'b0, 32'h0);
        query_addr = 5'd0;
        step();
        chk("t4_out_valid", 32'(ov[0]),  32'd1);
        chk("t4_wb_en",     32'(wbe[0]), 32'd0);
        chk("t4_query_hit", 32'(qh[0]),  32'd0);

        // Two writes to r7; youngest (0xA) should be forwarded.
        drive(1'b1, 1'b1, 5'd7, 32'hB, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b1, 5'd7, 32'hA, 1'b0, 32'h0);
        query_addr = 5'd7;
        step();
        chk("t5_query_hit", 32'(qh[1]), 32'd1);
`ifdef MW_WRITEBACK_FWD_EN
        chk("t5_fwd_data",  fwdd[1], 32'hA);
        chk("t5_fwd_valid", 32'(fv[1]), 32'd1);
`else
        chk("t5_fwd_data",  fwdd[1], 32'h0);
        chk("t5_fwd_valid", 32'(fv[1]), 32'd0);
`endif
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        step();
        for (int g = 0; g < ND; g++) begin
            chk("t5_rst_out_valid", 32'(ov[g]),  32'd0);
            chk("t5_rst_wb_en",     32'(wbe[g]), 32'd0);
            chk("t5_rst_wb_data",   wbd[g],      32'd0);
            chk("t5_rst_query_hit", 32'(qh[g]),  32'd0);
            chk("t5_rst_fwd_data",  fwdd[g],     32'd0);
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 7)),
                  $urandom, 1'($urandom), $urandom);
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 49) == 0);
            query_addr = 5'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
